// File: rtl/rom_ddram_port_if.sv
// ROM toggle-handshake bus: the download/68K side initiates, rom_ddram_port responds.
interface rom_ddram_port_if;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic [23:0] rdaddr;
  logic [15:0] dout;
  logic        rd_req;
  logic        rd_ack;

  modport master (output wraddr, din, we_req, rdaddr, rd_req,
                  input  we_ack, dout, rd_ack);
  modport slave  (input  wraddr, din, we_req, rdaddr, rd_req,
                  output we_ack, dout, rd_ack);
endinterface

// File: rtl/rom_ddram_port.sv
// ROM bus responder onto the DDR3 Avalon master, with a one-line 64-bit read cache.
module rom_ddram_port #(
  parameter logic [28:0] BASE = 29'h0600000
) (
  input  logic            clk_sys,
  input  logic            reset,
  rom_ddram_port_if.slave bus,
  input  logic            DDRAM_BUSY,
  output logic [7:0]      DDRAM_BURSTCNT,
  output logic [28:0]     DDRAM_ADDR,
  input  logic [63:0]     DDRAM_DOUT,
  input  logic            DDRAM_DOUT_READY,
  output logic            DDRAM_RD,
  output logic [63:0]     DDRAM_DIN,
  output logic [7:0]      DDRAM_BE,
  output logic            DDRAM_WE
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RDWAIT} state_t;

  state_t      state_q, state_d;
  logic        we_ack_q, we_ack_d, rd_ack_q, rd_ack_d;
  logic [15:0] dout_q, dout_d;
  logic        rd_q, rd_d, we_q, we_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] line_q, line_d;
  logic [21:0] tag_q, tag_d, rtag_q, rtag_d;
  logic        valid_q, valid_d;
  logic [1:0]  lane_q, lane_d;
  logic        drain_q, drain_d;
  logic        we_pend, rd_pend, hit;
  logic        unused_wr_bit0;

  assign we_pend        = bus.we_req != we_ack_q;
  assign rd_pend        = bus.rd_req != rd_ack_q;
  assign hit            = valid_q && (tag_q == bus.rdaddr[23:2]);
  assign unused_wr_bit0 = bus.wraddr[0];

  always_comb begin
    state_d  = state_q;
    we_ack_d = we_ack_q;
    rd_ack_d = rd_ack_q;
    dout_d   = dout_q;
    rd_d     = rd_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    be_d     = be_q;
    line_d   = line_q;
    tag_d    = tag_q;
    rtag_d   = rtag_q;
    valid_d  = valid_q;
    lane_d   = lane_q;

    // A read the DDR already accepted will still return data after a reset;
    // drain swallows that one beat so it cannot be mistaken for a new read.
    drain_d = drain_q;
    if (drain_q && DDRAM_DOUT_READY) drain_d = 1'b0;
    if (reset && ((state_q == RDWAIT && !DDRAM_DOUT_READY) ||
                  (state_q == READ && !DDRAM_BUSY)))
      drain_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (we_pend) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = BASE + 29'(bus.wraddr[24:3]);
          din_d   = {4{bus.din}};
          be_d    = 8'b11 << {bus.wraddr[2:1], 1'b0};
          if (tag_q == bus.wraddr[24:3])
            line_d[{bus.wraddr[2:1], 4'b0} +: 16] = bus.din;
        end else if (rd_pend) begin
          if (hit) begin
            dout_d   = line_q[{bus.rdaddr[1:0], 4'b0} +: 16];
            rd_ack_d = ~rd_ack_q;
          end else if (!drain_q) begin
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = BASE + 29'(bus.rdaddr[23:2]);
            rtag_d  = bus.rdaddr[23:2];
            lane_d  = bus.rdaddr[1:0];
          end
        end
      end
      WRITE: if (!DDRAM_BUSY) begin
        we_d     = 1'b0;
        we_ack_d = ~we_ack_q;
        state_d  = IDLE;
      end
      READ: if (!DDRAM_BUSY) begin
        rd_d    = 1'b0;
        state_d = RDWAIT;
      end
      RDWAIT: if (DDRAM_DOUT_READY) begin
        line_d   = DDRAM_DOUT;
        tag_d    = rtag_q;
        valid_d  = 1'b1;
        dout_d   = DDRAM_DOUT[{lane_q, 4'b0} +: 16];
        rd_ack_d = ~rd_ack_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      we_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      dout_q   <= '0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= BASE;
      din_q    <= '0;
      be_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_ack_q <= we_ack_d;
      rd_ack_q <= rd_ack_d;
      dout_q   <= dout_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      be_q     <= be_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      rtag_q   <= rtag_d;
      valid_q  <= valid_d;
      lane_q   <= lane_d;
    end
    drain_q <= drain_d;
  end

  assign bus.we_ack     = we_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.dout       = dout_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;
endmodule

// File: tb/tb_rom_ddram_port.sv
// Directed and randomized bench for rom_ddram_port against a small DDR responder model.
module tb_rom_ddram_port;
  localparam logic [28:0] BASE = 29'h0600000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  rom_ddram_port_if bus();
  logic        busy = 1'b0, rdy = 1'b0;
  logic [63:0] ddr_q = '0;
  logic [7:0]  burstcnt, be;
  logic [28:0] addr;
  logic        rd, we;
  logic [63:0] ddin;

  rom_ddram_port #(.BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus),
    .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt), .DDRAM_ADDR(addr),
    .DDRAM_DOUT(ddr_q), .DDRAM_DOUT_READY(rdy), .DDRAM_RD(rd),
    .DDRAM_DIN(ddin), .DDRAM_BE(be), .DDRAM_WE(we)
  );

  int errors = 0, checks = 0;

  // DDR model state
  logic [63:0] mem [logic [28:0]];
  int          cyc = 0, rd_cmds = 0, wr_cmds = 0, rd_hi = 0, addr_chg = 0, ack_tog = 0;
  int          rd_rise_cyc = -1, lat = 2, busy_hold = 0;
  bit          rand_mode = 1'b0;
  logic [28:0] last_rd_addr = '0, prev_addr = '0;
  logic        prev_rd = 1'b0, prev_ack = 1'b0;
  logic [28:0] pq_addr[$];
  int          pq_due[$];
  int          rlog[$];

  function automatic logic [63:0] mem_rd(input logic [28:0] a);
    logic [15:0] b;
    b = a[15:0] ^ 16'h5A00;
    if (mem.exists(a)) return mem[a];
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Responder: drives BUSY/READY at negedge and counts commands the next posedge accepts.
  initial forever begin
    logic [63:0] w;
    @(negedge clk_sys);
    cyc++;
    rdy = 1'b0;
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      ddr_q = mem_rd(pq_addr[0]);
      rdy   = 1'b1;
      rlog.push_back(cyc);
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    if (busy_hold > 0 && (rd || we)) begin busy = 1'b1; busy_hold--; end
    else if (rand_mode) busy = ($urandom_range(0, 2) == 0);
    else busy = 1'b0;
    if (rd) begin
      rd_hi++;
      if (prev_rd && addr !== prev_addr) addr_chg++;
      if (!prev_rd) rd_rise_cyc = cyc;
    end
    prev_rd = rd; prev_addr = addr;
    if (rd && !busy) begin
      rd_cmds++;
      last_rd_addr = addr;
      pq_addr.push_back(addr);
      pq_due.push_back(cyc + (rand_mode ? int'($urandom_range(1, 6)) : lat));
    end
    if (we && !busy) begin
      wr_cmds++;
      w = mem_rd(addr);
      for (int i = 0; i < 8; i++) if (be[i]) w[8*i +: 8] = ddin[8*i +: 8];
      mem[addr] = w;
    end
    if (bus.rd_ack !== prev_ack) ack_tog++;
    prev_ack = bus.rd_ack;
  end

  task automatic wait_rd(input int maxc, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < maxc) begin
      @(negedge clk_sys); n++;
      if (bus.rd_ack === bus.rd_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic rd_txn(input logic [23:0] a, output logic [15:0] d, output int n, output bit ok);
    bus.rdaddr = a;
    bus.rd_req = ~bus.rd_req;
    wait_rd(200, n, ok);
    d = bus.dout;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++; if (bus.we_ack !== 1'b0) begin errors++; $display("FAIL rst_we_ack got %h want 0", bus.we_ack); end
    checks++; if (bus.rd_ack !== 1'b0) begin errors++; $display("FAIL rst_rd_ack got %h want 0", bus.rd_ack); end
    checks++; if (bus.dout !== 16'h0) begin errors++; $display("FAIL rst_dout got %h want 0", bus.dout); end
    checks++; if (rd !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL rst_cmd got rd=%b we=%b want 0", rd, we); end
    checks++; if (addr !== BASE) begin errors++; $display("FAIL rst_addr got %h want %h", addr, BASE); end
    checks++; if (ddin !== 64'h0 || be !== 8'h0) begin errors++; $display("FAIL rst_din_be got %h/%h want 0", ddin, be); end
    checks++; if (burstcnt !== 8'd1) begin errors++; $display("FAIL rst_burstcnt got %h want 1", burstcnt); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_write();
    bus.wraddr = 25'h6; bus.din = 16'hBEEF; bus.we_req = ~bus.we_req;
    @(negedge clk_sys);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL wr_we_high got %b want 1", we); end
    checks++; if (addr !== BASE) begin errors++; $display("FAIL wr_addr got %h want %h", addr, BASE); end
    checks++; if (be !== 8'hC0) begin errors++; $display("FAIL wr_be got %h want c0", be); end
    checks++; if (ddin !== 64'hBEEF_BEEF_BEEF_BEEF) begin errors++; $display("FAIL wr_din got %h want beefbeefbeefbeef", ddin); end
    checks++; if (bus.we_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early got %b want 0", bus.we_ack); end
    @(negedge clk_sys);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL wr_we_drop got %b want 0", we); end
    checks++; if (bus.we_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", bus.we_ack); end
  endtask

  task automatic test_read_miss_hits();
    logic [15:0] exp_l [4];
    logic [15:0] d;
    int n, c0, h0;
    bit ok;
    exp_l = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    mem[BASE + 29'd4] = 64'h4444_3333_2222_1111;
    lat = 5; c0 = rd_cmds; h0 = rd_hi;
    rd_txn(24'h10, d, n, ok);
    checks++; if (!ok || d !== 16'h1111) begin errors++; $display("FAIL miss_data got %h ok=%0d want 1111", d, ok); end
    checks++; if (rd_cmds - c0 != 1 || rd_hi - h0 != 1) begin errors++; $display("FAIL miss_one_rd got cmds=%0d hi=%0d want 1/1", rd_cmds - c0, rd_hi - h0); end
    checks++; if (last_rd_addr !== BASE + 29'd4) begin errors++; $display("FAIL miss_addr got %h want %h", last_rd_addr, BASE + 29'd4); end
    for (int i = 1; i < 4; i++) begin
      rd_txn(24'h10 + 24'(i), d, n, ok);
      checks++; if (!ok || n != 1) begin errors++; $display("FAIL hit_lat word %0d got %0d cycles want 1", i, n); end
      checks++; if (d !== exp_l[i]) begin errors++; $display("FAIL hit_data word %0d got %h want %h", i, d, exp_l[i]); end
    end
    checks++; if (rd_cmds - c0 != 1) begin errors++; $display("FAIL hit_no_rd got %0d cmds want 1", rd_cmds - c0); end
  endtask

  task automatic test_busy();
    logic [15:0] d;
    int n, c0, h0, a0;
    bit ok;
    mem[BASE + 29'd16] = 64'hDDDD_CCCC_BBBB_AAAA;
    lat = 3; busy_hold = 3; c0 = rd_cmds; h0 = rd_hi; a0 = addr_chg;
    rd_txn(24'h40, d, n, ok);
    checks++; if (!ok || d !== 16'hAAAA) begin errors++; $display("FAIL busy_data got %h ok=%0d want aaaa", d, ok); end
    checks++; if (rd_hi - h0 != 4) begin errors++; $display("FAIL busy_rd_cycles got %0d want 4", rd_hi - h0); end
    checks++; if (rd_cmds - c0 != 1 || addr_chg != a0) begin errors++; $display("FAIL busy_cmd got cmds=%0d addr_chg=%0d want 1/0", rd_cmds - c0, addr_chg - a0); end
    checks++; if (last_rd_addr !== BASE + 29'd16) begin errors++; $display("FAIL busy_addr got %h want %h", last_rd_addr, BASE + 29'd16); end
  endtask

  task automatic test_same_edge();
    logic [15:0] d;
    int n, c0;
    bit ok;
    c0 = rd_cmds;
    bus.wraddr = 25'h84; bus.din = 16'h1234; bus.we_req = ~bus.we_req;
    bus.rdaddr = 24'h42; bus.rd_req = ~bus.rd_req;
    @(negedge clk_sys);
    checks++; if (we !== 1'b1 || rd !== 1'b0) begin errors++; $display("FAIL same_write_first got we=%b rd=%b want 1/0", we, rd); end
    checks++; if (be !== 8'h30) begin errors++; $display("FAIL same_be got %h want 30", be); end
    wait_rd(50, n, ok);
    d = bus.dout;
    checks++; if (!ok || bus.we_ack !== bus.we_req) begin errors++; $display("FAIL same_acks got rd_ok=%0d we_ack=%b want 1/%b", ok, bus.we_ack, bus.we_req); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL same_lane_update got %h want 1234", d); end
    checks++; if (rd_cmds != c0) begin errors++; $display("FAIL same_no_rd got %0d cmds want 0", rd_cmds - c0); end
  endtask

  task automatic test_drain();
    logic [15:0] d;
    int n, c0, r0, k;
    bit ok;
    lat = 8; c0 = rd_cmds;
    bus.rdaddr = 24'h80; bus.rd_req = ~bus.rd_req;
    k = 0;
    while (rd_cmds == c0 && k < 20) begin @(negedge clk_sys); k++; end
    checks++; if (rd_cmds == c0) begin errors++; $display("FAIL drain_issue got no rd within %0d cycles want 1", k); end
    @(negedge clk_sys);
    reset = 1'b1; bus.rd_req = 1'b0; bus.we_req = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    checks++; if (rd !== 1'b0 || bus.rd_ack !== 1'b0) begin errors++; $display("FAIL drain_reset got rd=%b ack=%b want 0/0", rd, bus.rd_ack); end
    mem[BASE + 29'h40] = 64'h8888_7777_6666_5555;
    lat = 2; r0 = rlog.size();
    rd_txn(24'h102, d, n, ok);
    checks++; if (!ok || d !== 16'h7777) begin errors++; $display("FAIL drain_data got %h ok=%0d want 7777", d, ok); end
    checks++; if (rlog.size() - r0 != 2 || rd_rise_cyc <= rlog[r0]) begin errors++; $display("FAIL drain_order got rd_rise=%0d stale_ready=%0d readys=%0d want rise after stale, 2 readys", rd_rise_cyc, rlog[r0], rlog.size() - r0); end
  endtask

  task automatic test_random();
    logic [15:0] d, e;
    logic [63:0] l;
    logic [23:0] a;
    int n, t0, done;
    bit ok;
    rand_mode = 1'b1; t0 = ack_tog; done = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom_range(0, 63));
      rd_txn(a, d, n, ok);
      l = mem_rd(BASE + 29'(a[23:2]));
      e = l[{a[1:0], 4'b0} +: 16];
      checks++;
      if (!ok || d !== e) begin errors++; $display("FAIL rand_read %0d addr %h got %h ok=%0d want %h", i, a, d, ok, e); end
      if (!ok) break;
      done++;
    end
    rand_mode = 1'b0;
    repeat (10) @(negedge clk_sys);
    checks++; if (ack_tog - t0 != done) begin errors++; $display("FAIL rand_ack_count got %0d toggles want %0d", ack_tog - t0, done); end
  endtask

  initial begin
    bus.wraddr = '0; bus.din = '0; bus.we_req = 1'b0;
    bus.rdaddr = '0; bus.rd_req = 1'b0;
    test_reset();
    test_write();
    test_read_miss_hits();
    test_busy();
    test_same_edge();
    test_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
